// File: rtl/readout_seq_pkg.sv
// readout_seq_pkg -- shared types and constants for the frame readout sequencer.
//   rdseq_state_t : sequencer FSM states
//   RDOUT_NWORDS  : data words per frame (the trailer word follows them)
//   RDOUT_SETTLE  : cycles between an increment and the matching ser_load
//   RDOUT_NLOADS  : total increments / loads per frame (data + trailer)
package readout_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    INC      = 3'd2,
    SETTLE   = 3'd3,
    LOAD     = 3'd4,
    WAIT_SER = 3'd5,
    GAP      = 3'd6,
    DONE     = 3'd7
  } rdseq_state_t;

  localparam int RDOUT_NWORDS = 53;
  localparam int RDOUT_SETTLE = 2;
  localparam int RDOUT_NLOADS = RDOUT_NWORDS + 1;
  localparam int WIDX_W       = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/readout_seq_timer.sv
// rdseq_timer -- loadable down-counter with a zero flag.
//   clk50, rst_n : clock, async active-low reset
//   load         : capture load_val (wins over dec)
//   dec          : count down by one, stopping at zero
//   load_val     : value captured on load
//   zero         : counter currently holds zero
module rdseq_timer #(
  parameter int W = 8
) (
  input  logic         clk50,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/readout_seq.sv
// readout_seq -- sequences one frame readout: clears the word-readout block,
// then for each of the 54 words issues increment, waits for the word to settle,
// loads the serializer and waits for it to finish, with an idle gap between
// words. The last word is recognised by rdout_done sampled at load time.
//
// Ports:
//   clk50, rst_n : 50 MHz clock, async active-low reset
//   start        : one-cycle frame request (honoured only in IDLE)
//   rdout_done   : word-readout block is presenting its final (trailer) word
//   ser_done     : serializer finished the loaded word
//   increment    : advance the word-readout block
//   clr_rdout    : clear the word-readout block's done flag
//   ser_load     : serializer captures the current word
//   busy         : frame in progress
//   word_idx     : increments issued this frame (saturates at 54)
//   frame_done   : one-cycle end-of-frame pulse
//   err          : sticky watchdog / missing-trailer flag
//
// Optional feature: define RDOUT_TIMEOUT_EN to add a WAIT_SER watchdog of
// TIMEOUT_CYC cycles. Without it err is constant 0 and WAIT_SER waits forever.
module readout_seq
  import readout_seq_pkg::*;
#(
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rdout_done,
  input  logic              ser_done,
  output logic              increment,
  output logic              clr_rdout,
  output logic              ser_load,
  output logic              busy,
  output logic [WIDX_W-1:0] word_idx,
  output logic              frame_done,
  output logic              err
);

  // One timer serves SETTLE, GAP and the watchdog; size it for the longest.
  localparam int TMR_MAX = max3(GAP_CYC, TIMEOUT_CYC, RDOUT_SETTLE);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Timer counts load_val..0 inclusive, so a load of N-1 gives N cycles.
  localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(RDOUT_SETTLE - 1);
  localparam logic [TMR_W-1:0]  GAP_LD    = (GAP_CYC > 0) ? TMR_W'(GAP_CYC - 1) : '0;
  localparam logic [WIDX_W-1:0] NLOADS_W  = WIDX_W'(RDOUT_NLOADS);

  rdseq_state_t     state, state_nxt;
  logic             last_word;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_ld_val;
  logic             ser_ev;
  logic             frame_full;

  assign frame_full = (word_idx == NLOADS_W);

  rdseq_timer #(.W(TMR_W)) u_timer (
    .clk50    (clk50),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_ld_val),
    .zero     (tmr_zero)
  );

`ifdef RDOUT_TIMEOUT_EN
  localparam logic [TMR_W-1:0] WDOG_LD = TMR_W'(TIMEOUT_CYC - 1);

  // Timeout stands in for ser_done so the word count stays aligned with
  // the readout block.
  logic wdog_fire;
  assign wdog_fire = (state == WAIT_SER) && tmr_zero && !ser_done;
  assign ser_ev    = ser_done || wdog_fire;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (wdog_fire ||
             ((state == WAIT_SER) && ser_ev && frame_full && !last_word))
      err <= 1'b1;
  end
`else
  assign ser_ev = ser_done;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_idx  <= '0;
      last_word <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        word_idx  <= '0;
        last_word <= 1'b0;
      end else if (state == INC && word_idx != NLOADS_W) begin
        word_idx <= word_idx + 1'b1;
      end
      if (state == LOAD) last_word <= rdout_done;
    end
  end

  always_comb begin
    state_nxt  = state;
    increment  = 1'b0;
    clr_rdout  = 1'b0;
    ser_load   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_ld_val = SETTLE_LD;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLR;
      end
      CLR: begin
        clr_rdout = 1'b1;
        state_nxt = INC;
      end
      INC: begin
        increment  = 1'b1;
        tmr_load   = 1'b1;
        tmr_ld_val = SETTLE_LD;
        state_nxt  = SETTLE;
      end
      SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_nxt = LOAD;
      end
      LOAD: begin
        ser_load = 1'b1;
`ifdef RDOUT_TIMEOUT_EN
        tmr_load   = 1'b1;
        tmr_ld_val = WDOG_LD;
`endif
        state_nxt = WAIT_SER;
      end
      WAIT_SER: begin
`ifdef RDOUT_TIMEOUT_EN
        tmr_dec = 1'b1;
`endif
        if (ser_ev) begin
          // A missing trailer flag must not run the frame past 54 words.
          if (last_word || frame_full) begin
            state_nxt = DONE;
          end else if (GAP_CYC == 0) begin
            state_nxt = INC;
          end else begin
            tmr_load   = 1'b1;
            tmr_ld_val = GAP_LD;
            state_nxt  = GAP;
          end
        end
      end
      GAP: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_nxt = INC;
      end
      DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/readout_seq.md
READOUT_SEQ -- requirements
Module: readout_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock clk50, reset rst_n.
REQ-002 Parameter GAP_CYC, default 16, sets idle clk50 cycles between a ser_done and the next increment.
REQ-003 Parameter TIMEOUT_CYC, default 4096, sets the ser_done watchdog limit in cycles (used only with RDOUT_TIMEOUT_EN).
REQ-004 clk50  input  1  50 MHz system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to read out one frame.
REQ-007 rdout_done  input  1  frame-complete flag from the word-readout block.
REQ-008 ser_done  input  1  single-cycle pulse: serializer finished the loaded 10-bit word.
REQ-009 increment  output  1  word-advance strobe to the word-readout block.
REQ-010 clr_rdout  output  1  clears the word-readout block's done flag.
REQ-011 ser_load  output  1  single-cycle pulse: serializer captures the current 10-bit word.
REQ-012 busy  output  1  high from accepting start until frame completion.
REQ-013 word_idx  output  7  number of increments issued in the current frame, 0..54.
REQ-014 frame_done  output  1  single-cycle pulse at frame end.
REQ-015 err  output  1  sticky watchdog flag (tied 0 without RDOUT_TIMEOUT_EN).

Function
REQ-016 FSM states SHALL be IDLE, CLR, INC, SETTLE, LOAD, WAIT_SER, GAP, DONE.
REQ-017 IDLE: start=1 -> CLR; busy=1 the following cycle; start outside IDLE SHALL be ignored.
REQ-018 CLR: clr_rdout=1 for exactly one cycle -> INC.
REQ-019 INC: increment=1 for exactly one cycle, word_idx+1 -> SETTLE; increment SHALL be low in every other state.
REQ-020 SETTLE: exactly 2 cycles, covering the readout block's edge-detect and register latency -> LOAD.
REQ-021 LOAD: ser_load=1 for one cycle; rdout_done is sampled into a last_word flag -> WAIT_SER.
REQ-022 WAIT_SER: hold until ser_done=1; then -> DONE if last_word=1, else -> GAP.
REQ-023 A ser_done arriving in any other state SHALL be ignored.
REQ-024 GAP: count GAP_CYC cycles -> INC; GAP_CYC=0 SHALL go straight to INC.
REQ-025 DONE: frame_done=1 for one cycle, busy=0, word_idx held -> IDLE.
REQ-026 A complete frame SHALL issue exactly 54 increments and 54 ser_load pulses: 53 data words plus the trailer (0x2BF).
REQ-027 word_idx SHALL saturate at 54.
REQ-028 If word_idx reaches 54 without last_word set, the block SHALL still exit via DONE.
REQ-029 In the case of REQ-028, err SHALL be set if RDOUT_TIMEOUT_EN is defined.
REQ-030 start coincident with frame_done SHALL be ignored; a new frame requires start while in IDLE.

Reset
REQ-031 rst_n=0 SHALL force the FSM to IDLE immediately.
REQ-032 rst_n=0 SHALL clear word_idx, last_word and err to 0.
REQ-033 rst_n=0 SHALL drive increment, clr_rdout, ser_load, busy and frame_done low.
REQ-034 Reset mid-frame SHALL abandon the frame with no further pulses, because the word-readout block shares rst_n and realigns to word 0.

Configuration
REQ-035 With macro RDOUT_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in WAIT_SER.
REQ-036 On reaching TIMEOUT_CYC, the watchdog SHALL set err and proceed as if ser_done had arrived, keeping the word count aligned.
REQ-037 Without RDOUT_TIMEOUT_EN, the watchdog logic SHALL be absent, err SHALL be constant 0, and WAIT_SER SHALL wait indefinitely.

Structure
REQ-038 The state typedef rdseq_state_t and constants RDOUT_NWORDS=53 and RDOUT_SETTLE=2 SHALL reside in the shared Types package.
REQ-039 One sub-module, rdseq_timer, SHALL be used: a loadable down-counter with a zero flag, shared by GAP and the watchdog.

Verification
REQ-040 Reset, then one start with ser_done returned 3 cycles after each ser_load -> 54 increments, 54 ser_loads, one clr_rdout, frame_done once, word_idx=54.
REQ-041 With the real word-readout block attached -> serializer sees words_in[0..52] in order followed by 0x2BF, and rdout_done=1 at the 54th load.
REQ-042 start pulsed while busy=1, and again coincident with frame_done -> no additional clr_rdout and no second frame.
REQ-043 GAP_CYC=0 and GAP_CYC=16 -> ser_done-to-increment spacing of 1 and 17 cycles respectively.
REQ-044 rst_n asserted at word 20 of a frame, then start again -> outputs low at once; the new frame delivers words_in[0] first.
REQ-045 RDOUT_TIMEOUT_EN defined, TIMEOUT_CYC=64, ser_done withheld for word 5 -> err=1 after 64 cycles, frame still completes with 54 loads; without the macro, err stays 0 and the FSM waits in WAIT_SER.
